// File: rtl/q16_divider.sv
// q16_divider -- unsigned fixed-point divider, radix-2 restoring, one
// quotient bit per clock.
//
// Computes (dividend << FRAC_BITS) / divisor. The quotient is in
// Q(WIDTH-FRAC_BITS).FRAC_BITS format.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        divide request; only a 0->1 edge seen while IDLE is accepted
//   dividend     unsigned integer numerator
//   divisor      unsigned integer denominator
//   quotient     result; all-ones on divide-by-zero or overflow
//   remainder    (dividend << FRAC_BITS) mod divisor; 0 on divide-by-zero
//   complete     one-cycle result-valid pulse, asserted while in DONE
//   busy         high whenever the FSM is not IDLE
//   div_by_zero  last result had divisor == 0
//   overflow     last true quotient did not fit in WIDTH bits (saturated)
module q16_divider #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             complete,
  output logic             busy,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int NW = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(NW);
  localparam logic [CW-1:0] CNT_INIT = CW'(NW - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic             start_d_q, start_d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  // Numerator bits shift out of the MSB while quotient bits shift in at
  // the LSB, so one register holds both.
  logic [NW-1:0]    nq_q, nq_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             complete_q, complete_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_nxt;
  logic [NW-1:0]    q_full;

  assign accept = (state_q == IDLE) && start && !start_d_q;

  // Shifted partial remainder is one bit wider than the divisor so the
  // trial subtraction cannot wrap; a clear MSB on diff means no borrow.
  assign trial   = {rem_q, nq_q[NW-1]};
  assign diff    = trial - {1'b0, dvs_q};
  assign qbit    = !diff[WIDTH];
  assign rem_nxt = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_full  = {nq_q[NW-2:0], qbit};

  always_comb begin
    state_d     = state_q;
    start_d_d   = start;
    cnt_d       = cnt_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    nq_d        = nq_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    complete_d  = 1'b0;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          dvs_d = divisor;
          nq_d  = {dividend, {FRAC_BITS{1'b0}}};
          rem_d = '0;
          cnt_d = CNT_INIT;
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b1;
            complete_d  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = rem_nxt;
        nq_d  = q_full;
        if (cnt_q == '0) begin
          state_d     = DONE;
          complete_d  = 1'b1;
          remainder_d = rem_nxt;
          // Any set bit above the WIDTH LSBs means the result saturates.
          if (|q_full[NW-1:WIDTH]) begin
            quotient_d = '1;
            ovf_d      = 1'b1;
          end else begin
            quotient_d = q_full[WIDTH-1:0];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      start_d_q   <= 1'b0;
      cnt_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      nq_q        <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      complete_q  <= 1'b0;
      busy_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_d_q   <= start_d_d;
      cnt_q       <= cnt_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      nq_q        <= nq_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      complete_q  <= complete_d;
      busy_q      <= busy_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign complete    = complete_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
